// File: rtl/trace_capture_mc.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : trace_capture_mc                                           |
// | Description : Multi-channel sensor trace capture with pre-trigger ring   |
// |               buffer, decimation and byte-serial UART frame readout.     |
// |               Optional macro TRACE_MARKER_EN tags cipher-done samples    |
// |               (253) and the trigger row (250) inside the stored data.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module trace_capture_mc #(
  parameter int NUM_CH   = 4,
  parameter int DEPTH    = 1024,
  parameter int PRE_TRIG = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [8*NUM_CH-1:0] sen_data,
  input  logic                arm,
  input  logic [7:0]          div,
  input  logic                trig,
  input  logic                enc_done,
  output logic                tx_dv,
  output logic [7:0]          tx_byte,
  input  logic                tx_done,
  output logic                busy,
  output logic                done
);

  localparam int c_aw     = $clog2(DEPTH);
  localparam int c_post_n = DEPTH - PRE_TRIG;
  localparam int c_bytes  = DEPTH * NUM_CH;
  localparam int c_bw     = $clog2(c_bytes);
  localparam int c_chw    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [c_aw:0]    c_pre_last  = (PRE_TRIG == 0) ? '0 : (c_aw+1)'(PRE_TRIG - 1);
  localparam logic [c_aw:0]    c_post_last = (c_aw+1)'(c_post_n - 1);
  localparam logic [c_bw-1:0]  c_last_byte = c_bw'(c_bytes - 1);
  localparam logic [c_chw-1:0] c_ch_last   = c_chw'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_HDR   = 3'd4,
    S_SEND  = 3'd5,
    S_WAIT  = 3'd6
  } state_t;

  state_t              r_state;
  logic [7:0]          r_div;
  logic [7:0]          r_dcnt;
  logic [c_aw-1:0]     r_wp;
  logic [c_aw:0]       r_cnt;
  logic                r_trig_q;
  logic [c_aw-1:0]     r_trig_row;
  logic [c_aw-1:0]     r_rd_row;
  logic [c_chw-1:0]    r_ch;
  logic [c_bw-1:0]     r_bcnt;
  logic [2:0]          r_hidx;
  logic                r_lat;
  logic [8*NUM_CH-1:0] r_rdata;
  logic [8*NUM_CH-1:0] r_mem [DEPTH];

  logic                w_tick;
  logic                w_rise;
  logic                w_capture;
  logic                w_wr_en;
  logic [8*NUM_CH-1:0] w_wdata;
  logic [7:0]          w_hdr_byte;
  logic [7:0]          w_data_byte;
  logic [15:0]         w_trig16;

  assign w_tick    = (r_dcnt == r_div);
  assign w_rise    = trig & ~r_trig_q;
  assign w_capture = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
  assign w_wr_en   = w_capture & w_tick;
  assign w_trig16  = 16'(r_trig_row);

`ifdef TRACE_MARKER_EN
  // The trigger row is the ARMED write that coincides with the edge, or the
  // first POST write when the edge arrived between ticks (r_cnt still 0).
  logic w_trig_wr;
  assign w_trig_wr = ((r_state == S_ARMED) & w_rise & w_tick) |
                     ((r_state == S_POST) & w_tick & (r_cnt == '0));
  for (genvar g = 0; g < NUM_CH; g++) begin : g_wdata
    assign w_wdata[8*g +: 8] = w_trig_wr ? 8'd250 :
                               (enc_done ? 8'd253 : sen_data[8*g +: 8]);
  end
`else
  logic w_unused;
  assign w_unused = enc_done;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_wdata
    assign w_wdata[8*g +: 8] = sen_data[8*g +: 8];
  end
`endif

  // Header byte sequence: sync, channel count, trigger row high, low
  always_comb begin
    case (r_hidx[1:0])
      2'd0:    w_hdr_byte = 8'hA5;
      2'd1:    w_hdr_byte = 8'(NUM_CH);
      2'd2:    w_hdr_byte = w_trig16[15:8];
      default: w_hdr_byte = w_trig16[7:0];
    endcase
  end

  // Select the current channel byte out of the registered RAM row
  always_comb begin
    w_data_byte = r_rdata[7:0];
    for (int i = 1; i < NUM_CH; i++)
      if (r_ch == c_chw'(i)) w_data_byte = r_rdata[8*i +: 8];
  end

  // Sample buffer: one row per tick, synchronous read of the readout row
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wp] <= w_wdata;
    r_rdata <= r_mem[r_rd_row];
  end

  // Capture and readout sequencer with registered UART-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_dcnt     <= '0;
      r_wp       <= '0;
      r_cnt      <= '0;
      r_trig_q   <= 1'b0;
      r_trig_row <= '0;
      r_rd_row   <= '0;
      r_ch       <= '0;
      r_bcnt     <= '0;
      r_hidx     <= '0;
      r_lat      <= 1'b0;
      tx_dv      <= 1'b0;
      tx_byte    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_trig_q <= trig;
      tx_dv    <= 1'b0;
      done     <= 1'b0;
      if (w_capture) r_dcnt <= w_tick ? 8'd0 : r_dcnt + 8'd1;
      if (w_wr_en)   r_wp   <= r_wp + 1'b1;
      case (r_state)
        S_IDLE: if (arm) begin
          r_div   <= div;
          r_dcnt  <= '0;
          r_wp    <= '0;
          r_cnt   <= '0;
          r_ch    <= '0;
          r_bcnt  <= '0;
          r_hidx  <= '0;
          r_lat   <= 1'b0;
          busy    <= 1'b1;
          r_state <= (PRE_TRIG == 0) ? S_ARMED : S_PRE;
        end
        S_PRE: if (w_tick) begin
          if (r_cnt == c_pre_last) begin
            r_cnt   <= '0;
            r_state <= S_ARMED;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ARMED: if (w_rise) begin
          // wp only moves on ticks, so it already names the trigger row
          r_trig_row <= r_wp;
          if (w_tick) begin
            if (c_post_n == 1) begin
              r_rd_row <= r_wp + 1'b1;
              r_state  <= S_HDR;
            end else begin
              r_cnt   <= {{c_aw{1'b0}}, 1'b1};
              r_state <= S_POST;
            end
          end else begin
            r_cnt   <= '0;
            r_state <= S_POST;
          end
        end
        S_POST: if (w_tick) begin
          if (r_cnt == c_post_last) begin
            r_rd_row <= r_wp + 1'b1;
            r_state  <= S_HDR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HDR: begin
          tx_dv   <= 1'b1;
          tx_byte <= w_hdr_byte;
          r_state <= S_WAIT;
        end
        S_SEND: begin
          // First cycle lets the RAM row settle into r_rdata
          if (!r_lat) begin
            r_lat <= 1'b1;
          end else begin
            r_lat   <= 1'b0;
            tx_dv   <= 1'b1;
            tx_byte <= w_data_byte;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: if (tx_done) begin
          if (r_hidx != 3'd4) begin
            r_hidx  <= r_hidx + 3'd1;
            r_state <= (r_hidx == 3'd3) ? S_SEND : S_HDR;
          end else if (r_bcnt == c_last_byte) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
            if (r_ch == c_ch_last) begin
              r_ch     <= '0;
              r_rd_row <= r_rd_row + 1'b1;
            end else begin
              r_ch <= r_ch + 1'b1;
            end
            r_state <= S_SEND;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trace_capture_mc.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_trace_capture_mc                                        |
// | Description : Self-checking bench for trace_capture_mc with a UART       |
// |               responder and a sample-level frame reference model.       |
// |               Honours TRACE_MARKER_EN when defined.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_trace_capture_mc;

  localparam int NUM_CH   = 2;
  localparam int DEPTH    = 16;
  localparam int PRE_TRIG = 4;
  localparam int MAXC     = 3000;
  localparam int NBYTES   = 4 + DEPTH * NUM_CH;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [8*NUM_CH-1:0] sen_data = '0;
  logic                arm = 1'b0;
  logic [7:0]          div = '0;
  logic                trig = 1'b0;
  logic                enc_done = 1'b0;
  logic                tx_dv;
  logic [7:0]          tx_byte;
  logic                tx_done;
  logic                busy;
  logic                done;

  int n_checks = 0;
  int n_errors = 0;

  // UART responder state and frame log
  logic [7:0] rx_q [$];
  int  dv_cnt = 0, done_cnt = 0, done_bytes = 0, done_pend = 0;
  int  viol = 0, hold_err = 0, uart_lat = 0;
  bit  spur_tog = 1'b0, spur_seen = 1'b0;

  // Stimulus history, one entry per cycle after arm
  logic [8*NUM_CH-1:0] h_data [MAXC];
  bit                  h_trig [MAXC];
  bit                  h_enc  [MAXC];

  trace_capture_mc #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG)) dut (
    .clk(clk), .reset(reset), .sen_data(sen_data), .arm(arm), .div(div),
    .trig(trig), .enc_done(enc_done), .tx_dv(tx_dv), .tx_byte(tx_byte),
    .tx_done(tx_done), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // UART transmitter model: tx_done a fixed or random delay after each tx_dv
  initial begin
    bit pend, done_prev, just_done;
    int wcnt;
    logic [7:0] held;
    pend = 0; done_prev = 0; wcnt = 0; held = '0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done   = 1'b0;
      just_done = done_prev;
      done_prev = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (tx_dv) begin
          dv_cnt++;
          rx_q.push_back(tx_byte);
          if (pend || just_done) viol++;
          pend = 1'b1;
          held = tx_byte;
          wcnt = (uart_lat > 0) ? uart_lat : int'($urandom_range(1, 6));
        end else if (pend) begin
          if (tx_byte !== held) hold_err++;
          wcnt--;
          if (wcnt == 0) begin
            tx_done = 1'b1; pend = 1'b0; done_prev = 1'b1;
          end
        end else if (spur_tog != spur_seen) begin
          spur_seen = spur_tog;
          tx_done = 1'b1;
        end
        if (done) begin
          done_cnt++; done_bytes = dv_cnt; done_pend = int'(pend);
        end
      end
    end
  end

  // One acquisition: t1 = single-cycle trig pulse, t2 = trig level from then on
  task automatic run_frame(input int div_v, input int t1, input int t2, input bit rnd,
                           input int lat, input int abort_at);
    int base_dv, base_done, base_viol, base_hold, base_rx, ncyc, ticks, k, need, dv_at;
    bit pre_ok, prevt, rise;
    logic [8*NUM_CH-1:0] samp [$];
    bit enc_s [$];
    int exp_b [$];
    logic [8*NUM_CH-1:0] row;
    int b;
    uart_lat = lat;
    trig = 1'b0; enc_done = 1'b0; arm = 1'b0;
    repeat (3) @(negedge clk);
    base_dv = dv_cnt; base_done = done_cnt; base_viol = viol;
    base_hold = hold_err; base_rx = rx_q.size();
    div = 8'(div_v);
    arm = 1'b1;
    ncyc = 0;
    for (int c = 0; c < MAXC; c++) begin
      @(negedge clk);
      arm = rnd && (c == 5);
      if (rnd && c == 6) spur_tog = ~spur_tog;
      for (int ch = 0; ch < NUM_CH; ch++)
        sen_data[8*ch +: 8] = rnd ? 8'($urandom) : 8'(c + 16*ch);
      if (rnd) trig = (c < 200) ? ($urandom_range(0, 3) == 0) : (c >= 204);
      else     trig = (c == t1) || (t2 >= 0 && c >= t2);
      enc_done = rnd && ($urandom_range(0, 5) == 0);
      h_data[c] = sen_data; h_trig[c] = trig; h_enc[c] = enc_done;
      ncyc = c + 1;
      if (dv_cnt != base_dv) break;
    end
    check("capture_ended", 32'(dv_cnt != base_dv), 32'd1);

    if (abort_at > 0) begin
      for (int w = 0; w < 3000 && (rx_q.size() - base_rx) < abort_at; w++) @(negedge clk);
      check("abort_reached", 32'((rx_q.size() - base_rx) >= abort_at), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_tx_dv", 32'(tx_dv), 32'd0);
      check("async_rst_tx_byte", 32'(tx_byte), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      dv_at = dv_cnt;
      repeat (60) @(negedge clk);
      check("no_stray_dv", 32'(dv_cnt - dv_at), 32'd0);
      check("idle_after_abort", 32'(busy), 32'd0);
      return;
    end

    // Reference: walk the cycles, collecting one sample per tick
    ticks = 0; k = -1; pre_ok = (PRE_TRIG == 0); prevt = 1'b0;
    need = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (k >= 0 && ticks >= k + DEPTH - PRE_TRIG) break;
      rise  = h_trig[c] && !prevt;
      prevt = h_trig[c];
      if (pre_ok && rise && k < 0) k = ticks;
      if ((c % (div_v + 1)) == div_v) begin
        samp.push_back(h_data[c]); enc_s.push_back(h_enc[c]);
        ticks++;
        if (ticks >= PRE_TRIG) pre_ok = 1'b1;
      end
    end
    need = (k < 0) ? MAXC : k + DEPTH - PRE_TRIG;
    check("capture_length", 32'(ticks >= need), 32'd1);
    if (ticks < need) return;

    exp_b.push_back(8'hA5);
    exp_b.push_back(NUM_CH);
    exp_b.push_back(((k % DEPTH) >> 8) & 255);
    exp_b.push_back((k % DEPTH) & 255);
    for (int j = 0; j < DEPTH; j++) begin
      int s;
      s = k - PRE_TRIG + j;
      row = samp[s];
      for (int ch = 0; ch < NUM_CH; ch++) begin
        b = int'(row[8*ch +: 8]);
`ifdef TRACE_MARKER_EN
        if (s == k) b = 250;
        else if (enc_s[s]) b = 253;
`endif
        exp_b.push_back(b);
      end
    end

    for (int w = 0; w < 8000 && done_cnt == base_done; w++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("done_pulses", 32'(done_cnt - base_done), 32'd1);
    check("done_after_last", 32'(done_bytes - base_dv), 32'(NBYTES));
    check("done_nothing_pending", 32'(done_pend), 32'd0);
    check("tx_dv_count", 32'(dv_cnt - base_dv), 32'(NBYTES));
    check("handshake_order", 32'(viol - base_viol), 32'd0);
    check("tx_byte_hold", 32'(hold_err - base_hold), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    for (int i = 0; i < NBYTES; i++)
      check($sformatf("byte%0d", i),
            (base_rx + i < rx_q.size()) ? 32'(rx_q[base_rx + i]) : 32'hFFFF_FFFF,
            32'(exp_b[i]));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx_dv", 32'(tx_dv), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_frame(0, -1,  9, 1'b0,   0, 0);   // ramp, trig 10 cycles after arm
    run_frame(3, -1, 40, 1'b0,   0, 0);   // decimation by 4
    run_frame(0,  2, 20, 1'b0,   0, 0);   // early pulse during pre-fill ignored
    run_frame(1, -1, 30, 1'b0, 100, 0);   // slow UART
    run_frame(2, -1, 30, 1'b0,   0, 10);  // reset during readout
    run_frame(0, -1, 15, 1'b0,   0, 0);   // fresh frame after the abort
    for (int r = 0; r < 5; r++)
      run_frame(int'($urandom_range(0, 4)), -1, -1, 1'b1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trace_capture_mc.md
TRACE_CAPTURE_MC -- requirements
Module: trace_capture_mc

Interface
REQ-001 Parameter NUM_CH, default 4: number of on-chip sensor channels, 1..8.
REQ-002 Parameter DEPTH, default 1024: samples per channel, a power of two, 16..4096.
REQ-003 Parameter PRE_TRIG, default 64: pre-trigger samples per channel, 0..DEPTH-1.
REQ-004 Port clk, input, 1: sole clock; all sampling and UART handshakes run on it.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port sen_data, input, 8*NUM_CH: processed sensor codes; channel c occupies bits [8c+7:8c].
REQ-007 Port arm, input, 1: single-cycle pulse; starts an acquisition from IDLE.
REQ-008 Port div, input, 8: decimation value, latched on arm; one sample every div+1 cycles.
REQ-009 Port trig, input, 1: cipher-start strobe (level or pulse); its rising edge is the trigger.
REQ-010 Port enc_done, input, 1: cipher-done flag, sampled with the data.
REQ-011 Port tx_dv, output, 1: one-cycle request to the UART transmitter.
REQ-012 Port tx_byte, output, 8: byte to transmit; valid while tx_dv=1.
REQ-013 Port tx_done, input, 1: one-cycle pulse from the UART when the byte has been sent.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port done, output, 1: one-cycle pulse after the last byte's tx_done.

Function
REQ-016 FSM states: IDLE, PRE (pre-trigger fill), ARMED, POST, HDR, SEND, WAIT.
REQ-017 IDLE->PRE on arm: latch div, clear write pointer wp, counters and decimation counter; arm in any other state is ignored.
REQ-018 A sample tick occurs when the decimation counter equals the latched div; the counter then wraps to 0, otherwise it increments.
REQ-019 On each tick in PRE/ARMED/POST: write all NUM_CH channel bytes at buffer row wp, then wp <= wp+1 modulo DEPTH.
REQ-020 PRE->ARMED when PRE_TRIG samples have been written; with PRE_TRIG=0, go straight to ARMED.
REQ-021 Rising edges of trig in PRE are ignored; ARMED keeps writing circularly, overwriting the oldest rows.
REQ-022 ARMED->POST on the first trig rising edge; the trigger row is the one written in that cycle, or the next tick's row if none is written.
REQ-023 POST writes DEPTH-PRE_TRIG rows counted from the trigger row, then goes to HDR; the start row is wp at exit.
REQ-024 HDR transmits 0xA5, NUM_CH and the trigger row index modulo DEPTH (high byte, then low byte), then goes to SEND.
REQ-025 SEND order: row start .. start+DEPTH-1 modulo DEPTH, channel 0 first within each row; DEPTH*NUM_CH bytes in total.
REQ-026 Every byte: assert tx_dv for one cycle with tx_byte stable, go to WAIT, hold tx_byte until tx_done, and issue the next tx_dv no earlier than the cycle after tx_done.
REQ-027 After the final tx_done: pulse done and return to IDLE; trig and sen_data are ignored during HDR, SEND and WAIT.
REQ-028 Buffer depth is DEPTH*NUM_CH bytes in a synchronous-read RAM; one cycle of read latency is absorbed before tx_dv.
REQ-029 A tx_done seen outside WAIT is ignored.

Reset
REQ-030 Asynchronous assertion of reset forces IDLE and sets tx_dv=0, tx_byte=0, busy=0, done=0, wp=0 and all counters to 0; buffer contents are undefined.
REQ-031 Reset mid-transmission abandons the frame; no further tx_dv is issued until the next arm.

Configuration
REQ-032 Macro TRACE_MARKER_EN defined: a sample with enc_done=1 stores 253 in every channel byte instead of sen_data.
REQ-033 With TRACE_MARKER_EN, the trigger row stores 250 in every channel.
REQ-034 Macro TRACE_MARKER_EN undefined: raw sen_data is always stored, and the header alone locates the trigger.

Verification
REQ-035 NUM_CH=2, DEPTH=16, PRE_TRIG=4, div=0, sen_data ramp, trig 10 cycles after arm -> header A5 02 then trigger index; 32 bytes, the first 8 being the 4 rows before the trigger.
REQ-036 div=3 -> consecutive stored rows differ by 4 ramp steps; the frame length is unchanged.
REQ-037 trig pulse 2 cycles after arm with PRE_TRIG=4 -> ignored; the second trig edge is the one used.
REQ-038 UART model with tx_done 100 cycles after each tx_dv -> exactly one tx_dv per tx_done, and the done pulse follows byte 4+DEPTH*NUM_CH.
REQ-039 With TRACE_MARKER_EN, enc_done high 5 rows after the trigger -> that row reads 253 253 and the trigger row reads 250 250.
REQ-040 reset asserted during SEND, then arm -> a fresh complete frame with no stray tx_dv in between.
